// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the power-on reset sequencer.
// State encoding, reset-cause codes and a small parameter helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        RS_ASSERT  = 2'd0,
        RS_STRETCH = 2'd1,
        RS_RELEASE = 2'd2,
        RS_RUN     = 2'd3
    } rs_state_t;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_EXT  = 2'd1;
    localparam logic [1:0] CAUSE_SOFT = 2'd2;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/por_reset_sequencer_if.sv
// Sequencer-to-domain bundle: soft request and acks in, per-domain resets and status out.
// master = sequencer side, slave = the domains / firmware side.
interface por_reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic              soft_reset_req;
    logic [STAGES-1:0] stage_ack;
    logic [STAGES-1:0] rst_n_o;
    logic              seq_done;
    logic              timeout_err;
    logic [1:0]        reset_cause;

    modport master (
        input  soft_reset_req, stage_ack,
        output rst_n_o, seq_done, timeout_err, reset_cause
    );

    modport slave (
        output soft_reset_req, stage_ack,
        input  rst_n_o, seq_done, timeout_err, reset_cause
    );
endinterface

// File: rtl/reset_sync_cell.sv
// DEPTH-flop synchronizer with asynchronous active-low clear to 0.
// Latency DEPTH cycles from i_d to o_q.
module reset_sync_cell #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [DEPTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[DEPTH-1];
endmodule

// File: rtl/por_reset_sequencer.sv
// Per-domain reset sequencer: asserts all resets at once, releases them in order gated by acks.
// Outputs are registered; aborts take one edge, porb_l clears everything asynchronously.
module por_reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STAGES         = 3,
    parameter int SYNC_DEPTH     = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int ACK_TIMEOUT    = 256
) (
    input  logic                   core_clk,
    input  logic                   porb_l,
    input  logic                   ext_reset_n,
    por_reset_sequencer_if.master  bus
);
    localparam int CNT_MAX = imax(STRETCH_CYCLES, ACK_TIMEOUT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST     = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(STAGES - 1);

    rs_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [STAGES-1:0] r_rst_n;
    logic              r_done;
    logic              r_terr;
    logic [1:0]        r_cause;

    logic              w_ext_sync;
    logic              w_abort;
    logic              w_ack;
    logic [IDX_W-1:0]  w_idx_nxt;

    reset_sync_cell #(
        .DEPTH (SYNC_DEPTH)
    ) u_ext_sync (
        .i_clk   (core_clk),
        .i_rst_n (porb_l),
        .i_d     (ext_reset_n),
        .o_q     (w_ext_sync)
    );

    assign w_abort   = !w_ext_sync || bus.soft_reset_req;
    assign w_ack     = bus.stage_ack[r_idx];
    assign w_idx_nxt = r_idx + 1'b1;

    always_ff @(posedge core_clk or negedge porb_l) begin
        if (!porb_l) begin
            r_state <= RS_ASSERT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
            r_cause <= CAUSE_POR;
        end else if (r_state != RS_ASSERT && w_abort) begin
            // Abort outranks ack and timeout; pad reset outranks soft request for the cause.
            r_state <= RS_ASSERT;
            r_cnt   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
            r_cause <= !w_ext_sync ? CAUSE_EXT : CAUSE_SOFT;
        end else begin
            case (r_state)
                RS_ASSERT: begin
                    r_rst_n <= '0;
                    if (w_ext_sync && !bus.soft_reset_req) begin
                        r_state <= RS_STRETCH;
                        r_cnt   <= '0;
                    end
                end
                RS_STRETCH: begin
                    if (r_cnt == STRETCH_LAST) begin
                        r_state    <= RS_RELEASE;
                        r_idx      <= '0;
                        r_rst_n[0] <= 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RS_RELEASE: begin
                    if (w_ack || r_cnt == ACK_LAST) begin
                        // A missing ack only flags the error; sequencing still moves on.
                        if (!w_ack) begin
                            r_terr <= 1'b1;
                        end
                        r_cnt <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_state <= RS_RUN;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx              <= w_idx_nxt;
                            r_rst_n[w_idx_nxt] <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rst_n_o     = r_rst_n;
    assign bus.seq_done    = r_done;
    assign bus.timeout_err = r_terr;
    assign bus.reset_cause = r_cause;
endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed bench for por_reset_sequencer (ACK_TIMEOUT overridden to 8, other parameters default).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_por_reset_sequencer;
    logic core_clk;
    logic porb_l;
    logic ext_reset_n;
    int   checks;
    int   failures;

    por_reset_sequencer_if #(.STAGES(3)) bus ();

    por_reset_sequencer #(
        .STAGES         (3),
        .SYNC_DEPTH     (2),
        .STRETCH_CYCLES (16),
        .ACK_TIMEOUT    (8)
    ) dut (
        .core_clk    (core_clk),
        .porb_l      (porb_l),
        .ext_reset_n (ext_reset_n),
        .bus         (bus)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge core_clk);
            #1;
        end
    endtask

    // Leaves porb_l high just after an edge, so the next rising edge is edge 1.
    task automatic por_start();
        porb_l = 1'b0;
        ext_reset_n = 1'b1;
        bus.soft_reset_req = 1'b0;
        @(posedge core_clk);
        #1;
        porb_l = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.rst_n_o !== 3'b000 || bus.seq_done !== 1'b0 || bus.timeout_err !== 1'b0 || bus.reset_cause !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got rst=%b done=%b terr=%b cause=%0d exp rst=000 done=0 terr=0 cause=0",
                     bus.rst_n_o, bus.seq_done, bus.timeout_err, bus.reset_cause);
        end
        tick(3);
        checks++;
        if (bus.rst_n_o !== 3'b000) begin
            failures++;
            $display("FAIL reset_held got=%b exp=000", bus.rst_n_o);
        end
    endtask

    task automatic test_por_acks_high();
        bus.stage_ack = 3'b111;
        por_start();
        tick(18);
        checks++;
        if (bus.rst_n_o !== 3'b000) begin
            failures++;
            $display("FAIL por_e18 got=%b exp=000", bus.rst_n_o);
        end
        tick(1);
        checks++;
        if (bus.rst_n_o !== 3'b001) begin
            failures++;
            $display("FAIL por_e19 got=%b exp=001", bus.rst_n_o);
        end
        tick(1);
        checks++;
        if (bus.rst_n_o !== 3'b011) begin
            failures++;
            $display("FAIL por_e20 got=%b exp=011", bus.rst_n_o);
        end
        tick(1);
        checks++;
        if (bus.rst_n_o !== 3'b111) begin
            failures++;
            $display("FAIL por_e21 got=%b exp=111", bus.rst_n_o);
        end
        tick(1);
        checks++;
        if (bus.seq_done !== 1'b1 || bus.reset_cause !== 2'd0 || bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL por_done got done=%b cause=%0d terr=%b exp done=1 cause=0 terr=0",
                     bus.seq_done, bus.reset_cause, bus.timeout_err);
        end
    endtask

    task automatic test_timeout();
        bus.stage_ack = 3'b101;
        por_start();
        tick(20);
        checks++;
        if (bus.rst_n_o !== 3'b011) begin
            failures++;
            $display("FAIL to_e20 got=%b exp=011", bus.rst_n_o);
        end
        tick(7);
        checks++;
        if (bus.rst_n_o !== 3'b011 || bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL to_e27 got rst=%b terr=%b exp rst=011 terr=0", bus.rst_n_o, bus.timeout_err);
        end
        tick(1);
        checks++;
        if (bus.rst_n_o !== 3'b111 || bus.timeout_err !== 1'b1 || bus.seq_done !== 1'b0) begin
            failures++;
            $display("FAIL to_e28 got rst=%b terr=%b done=%b exp rst=111 terr=1 done=0",
                     bus.rst_n_o, bus.timeout_err, bus.seq_done);
        end
        tick(1);
        checks++;
        if (bus.seq_done !== 1'b1) begin
            failures++;
            $display("FAIL to_done got=%b exp=1", bus.seq_done);
        end
    endtask

    task automatic test_soft_in_run();
        bus.stage_ack = 3'b111;
        bus.soft_reset_req = 1'b1;
        tick(1);
        bus.soft_reset_req = 1'b0;
        checks++;
        if (bus.rst_n_o !== 3'b000 || bus.seq_done !== 1'b0 || bus.reset_cause !== 2'd2 || bus.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL soft_abort got rst=%b done=%b cause=%0d terr=%b exp rst=000 done=0 cause=2 terr=1",
                     bus.rst_n_o, bus.seq_done, bus.reset_cause, bus.timeout_err);
        end
        tick(16);
        checks++;
        if (bus.rst_n_o !== 3'b000) begin
            failures++;
            $display("FAIL soft_a16 got=%b exp=000", bus.rst_n_o);
        end
        tick(1);
        checks++;
        if (bus.rst_n_o !== 3'b001) begin
            failures++;
            $display("FAIL soft_a17 got=%b exp=001", bus.rst_n_o);
        end
        tick(3);
        checks++;
        if (bus.rst_n_o !== 3'b111 || bus.seq_done !== 1'b1 || bus.timeout_err !== 1'b1 || bus.reset_cause !== 2'd2) begin
            failures++;
            $display("FAIL soft_rerun got rst=%b done=%b terr=%b cause=%0d exp rst=111 done=1 terr=1 cause=2",
                     bus.rst_n_o, bus.seq_done, bus.timeout_err, bus.reset_cause);
        end
    endtask

    task automatic test_ext_abort();
        bus.stage_ack = 3'b101;
        por_start();
        tick(20);
        ext_reset_n = 1'b0;
        tick(2);
        checks++;
        if (bus.rst_n_o !== 3'b011) begin
            failures++;
            $display("FAIL ext_e22 got=%b exp=011", bus.rst_n_o);
        end
        bus.soft_reset_req = 1'b1;
        tick(1);
        checks++;
        if (bus.rst_n_o !== 3'b000 || bus.reset_cause !== 2'd1 || bus.seq_done !== 1'b0) begin
            failures++;
            $display("FAIL ext_abort got rst=%b cause=%0d done=%b exp rst=000 cause=1 done=0",
                     bus.rst_n_o, bus.reset_cause, bus.seq_done);
        end
        ext_reset_n = 1'b1;
        bus.soft_reset_req = 1'b0;
        tick(18);
        checks++;
        if (bus.rst_n_o !== 3'b000 || bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL ext_e41 got rst=%b terr=%b exp rst=000 terr=0", bus.rst_n_o, bus.timeout_err);
        end
        tick(1);
        checks++;
        if (bus.rst_n_o !== 3'b001) begin
            failures++;
            $display("FAIL ext_resume got=%b exp=001", bus.rst_n_o);
        end
    endtask

    task automatic test_abort_vs_ack();
        bus.stage_ack = 3'b101;
        bus.soft_reset_req = 1'b1;
        tick(1);
        bus.soft_reset_req = 1'b0;
        checks++;
        if (bus.rst_n_o !== 3'b000 || bus.reset_cause !== 2'd2) begin
            failures++;
            $display("FAIL abort_vs_ack got rst=%b cause=%0d exp rst=000 cause=2", bus.rst_n_o, bus.reset_cause);
        end
        tick(1);
        checks++;
        if (bus.rst_n_o !== 3'b000) begin
            failures++;
            $display("FAIL abort_vs_ack_hold got=%b exp=000", bus.rst_n_o);
        end
    endtask

    task automatic test_por_mid_stretch();
        bus.stage_ack = 3'b111;
        por_start();
        tick(10);
        porb_l = 1'b0;
        #1;
        checks++;
        if (bus.rst_n_o !== 3'b000 || bus.seq_done !== 1'b0 || bus.reset_cause !== 2'd0) begin
            failures++;
            $display("FAIL por_stretch got rst=%b done=%b cause=%0d exp rst=000 done=0 cause=0",
                     bus.rst_n_o, bus.seq_done, bus.reset_cause);
        end
    endtask

    task automatic test_por_mid_run();
        bus.stage_ack = 3'b101;
        por_start();
        tick(28);
        bus.stage_ack = 3'b111;
        tick(1);
        checks++;
        if (bus.seq_done !== 1'b1 || bus.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL run_pre got done=%b terr=%b exp done=1 terr=1", bus.seq_done, bus.timeout_err);
        end
        porb_l = 1'b0;
        #1;
        checks++;
        if (bus.rst_n_o !== 3'b000 || bus.seq_done !== 1'b0 || bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL por_run got rst=%b done=%b terr=%b exp rst=000 done=0 terr=0",
                     bus.rst_n_o, bus.seq_done, bus.timeout_err);
        end
        por_start();
        tick(18);
        checks++;
        if (bus.rst_n_o !== 3'b000) begin
            failures++;
            $display("FAIL por_rep_e18 got=%b exp=000", bus.rst_n_o);
        end
        tick(1);
        checks++;
        if (bus.rst_n_o !== 3'b001) begin
            failures++;
            $display("FAIL por_rep_e19 got=%b exp=001", bus.rst_n_o);
        end
        tick(3);
        checks++;
        if (bus.rst_n_o !== 3'b111 || bus.seq_done !== 1'b1 || bus.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL por_rep_done got rst=%b done=%b terr=%b exp rst=111 done=1 terr=0",
                     bus.rst_n_o, bus.seq_done, bus.timeout_err);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        porb_l = 1'b0;
        ext_reset_n = 1'b1;
        bus.soft_reset_req = 1'b0;
        bus.stage_ack = 3'b000;
        test_reset();
        test_por_acks_high();
        test_timeout();
        test_soft_in_run();
        test_ext_abort();
        test_abort_vs_ack();
        test_por_mid_stretch();
        test_por_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
